// File: rtl/dig_mon_pkg.sv
// Shared encodings for the digital output monitor: sequence FSM states,
// read-select codes and the default detected code sequence.
package dig_mon_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_A    = 2'd1,
    S_AB   = 2'd2
  } seq_state_t;

  localparam logic [1:0] SEL_CH0 = 2'd0;
  localparam logic [1:0] SEL_CH1 = 2'd1;
  localparam logic [1:0] SEL_CH2 = 2'd2;
  localparam logic [1:0] SEL_SEQ = 2'd3;

  // Codes are in {OUT3,OUT2,OUT1} order
  localparam logic [2:0] DEF_PAT_A = 3'b111;
  localparam logic [2:0] DEF_PAT_B = 3'b010;
  localparam logic [2:0] DEF_PAT_C = 3'b101;

endpackage

// File: rtl/dig_evt_counter.sv
// Event counter with synchronous clear. Saturates at all-ones by default;
// with DIG_MON_WRAP_EN defined it wraps to zero and sets a sticky OVF bit.
module dig_evt_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             INC,
  output logic [CNT_W-1:0] CNT,
  output logic             OVF
);

  localparam logic [CNT_W-1:0] CntMax = '1;

`ifdef DIG_MON_WRAP_EN
  // Wrapping count with sticky overflow; CLR beats a same-cycle increment
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      CNT <= '0;
      OVF <= 1'b0;
    end else if (CLR) begin
      CNT <= '0;
      OVF <= 1'b0;
    end else if (INC) begin
      if (CNT == CntMax) begin
        CNT <= '0;
        OVF <= 1'b1;
      end else begin
        CNT <= CNT + 1'b1;
      end
    end
  end
`else
  // Saturating count; CLR beats a same-cycle increment
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      CNT <= '0;
    end else if (CLR) begin
      CNT <= '0;
    end else if (INC && (CNT != CntMax)) begin
      CNT <= CNT + 1'b1;
    end
  end

  assign OVF = 1'b0;
`endif

endmodule

// File: rtl/dig_out_monitor.sv
// Monitor for the three-bit gate-stage output vector: re-registers it, counts
// per-channel rising edges, detects a three-code sequence and exposes all four
// counters through a one-cycle read handshake.
// Optional build macro DIG_MON_WRAP_EN: wrapping counters with sticky overflow
// bits, RD_DATA widened by one bit carrying the overflow flag as MSB.
module dig_out_monitor
  import dig_mon_pkg::*;
#(
  parameter int unsigned CNT_W = 8,
  parameter logic [2:0]  PAT_A = DEF_PAT_A,
  parameter logic [2:0]  PAT_B = DEF_PAT_B,
  parameter logic [2:0]  PAT_C = DEF_PAT_C
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [2:0]       OUT_VEC,
  input  logic             CLR,
  input  logic             RD_REQ,
  input  logic [1:0]       RD_SEL,
`ifdef DIG_MON_WRAP_EN
  output logic [CNT_W:0]   RD_DATA,
`else
  output logic [CNT_W-1:0] RD_DATA,
`endif
  output logic             RD_VALID,
  output logic [2:0]       EDGE_FLAGS,
  output logic             SEQ_DET
);

  logic [2:0]       s0, s1;
  logic             v0, v1;
  seq_state_t       state;
  logic [2:0]       edge_vec;
  logic             code_chg;
  logic             seq_hit;
  logic [3:0]       inc;
  logic [CNT_W-1:0] cnt [4];
  logic [3:0]       ovf;
  logic [CNT_W-1:0] rd_cnt;

  // Input re-register plus validity shift; CLR deliberately leaves this alone
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s0 <= 3'b000;
      s1 <= 3'b000;
      v0 <= 1'b0;
      v1 <= 1'b0;
    end else begin
      s0 <= OUT_VEC;
      s1 <= s0;
      v0 <= 1'b1;
      v1 <= v0;
    end
  end

  // Edge and code-change detection, gated until the pipeline is primed
  always_comb begin
    edge_vec = s0 & ~s1 & {3{v1}};
    code_chg = v1 && (s0 != s1);
    seq_hit  = code_chg && (state == S_AB) && (s0 == PAT_C);
    inc      = {seq_hit, edge_vec};
  end

  // Sequence FSM with registered edge and detect pulses
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      EDGE_FLAGS <= 3'b000;
      SEQ_DET    <= 1'b0;
    end else if (CLR) begin
      state      <= S_IDLE;
      EDGE_FLAGS <= 3'b000;
      SEQ_DET    <= 1'b0;
    end else begin
      EDGE_FLAGS <= edge_vec;
      SEQ_DET    <= seq_hit;
      if (code_chg) begin
        case (state)
          S_IDLE: if (s0 == PAT_A) state <= S_A;
          S_A: begin
            if (s0 == PAT_B)      state <= S_AB;
            else if (s0 == PAT_A) state <= S_A;
            else                  state <= S_IDLE;
          end
          S_AB: begin
            // A completed sequence may also start the next one
            if (s0 == PAT_C)      state <= (PAT_C == PAT_A) ? S_A : S_IDLE;
            else if (s0 == PAT_A) state <= S_A;
            else                  state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Three channel counters plus the sequence counter (index 3)
  for (genvar g = 0; g < 4; g++) begin : g_cnt
    dig_evt_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .CLK(CLK),
      .RST(RST),
      .CLR(CLR),
      .INC(inc[g]),
      .CNT(cnt[g]),
      .OVF(ovf[g])
    );
  end

  // Read-select mux over the current (pre-update) counter values
  always_comb begin
    rd_cnt = cnt[0];
    case (RD_SEL)
      SEL_CH0: rd_cnt = cnt[0];
      SEL_CH1: rd_cnt = cnt[1];
      SEL_CH2: rd_cnt = cnt[2];
      SEL_SEQ: rd_cnt = cnt[3];
      default: rd_cnt = cnt[0];
    endcase
  end

`ifdef DIG_MON_WRAP_EN
  logic rd_ovf;

  // Overflow flag for the selected counter
  always_comb begin
    rd_ovf = ovf[RD_SEL];
  end

  // One-cycle read strobe; data holds until the next request
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RD_VALID <= 1'b0;
      RD_DATA  <= '0;
    end else begin
      RD_VALID <= RD_REQ;
      if (RD_REQ) RD_DATA <= {rd_ovf, rd_cnt};
    end
  end
`else
  logic unused_ovf;
  assign unused_ovf = ^ovf;

  // One-cycle read strobe; data holds until the next request
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RD_VALID <= 1'b0;
      RD_DATA  <= '0;
    end else begin
      RD_VALID <= RD_REQ;
      if (RD_REQ) RD_DATA <= rd_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_dig_out_monitor.sv
// Directed bench for dig_out_monitor (CNT_W=4): vector table for priming,
// edge counting and sequence detection, plus hand sequences for CLR/read
// collision, saturation and asynchronous reset during a read.
module tb_dig_out_monitor;

  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst;
  logic [2:0]    out_vec;
  logic          clr;
  logic          rd_req;
  logic [1:0]    rd_sel;
`ifdef DIG_MON_WRAP_EN
  logic [CW:0]   rd_data;
`else
  logic [CW-1:0] rd_data;
`endif
  logic          rd_valid;
  logic [2:0]    edge_flags;
  logic          seq_det;

  int n_checks = 0;
  int n_errors = 0;

  dig_out_monitor #(
    .CNT_W(CW)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .OUT_VEC(out_vec),
    .CLR(clr),
    .RD_REQ(rd_req),
    .RD_SEL(rd_sel),
    .RD_DATA(rd_data),
    .RD_VALID(rd_valid),
    .EDGE_FLAGS(edge_flags),
    .SEQ_DET(seq_det)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] vec;
    logic       req;
    logic [1:0] sel;
    logic [2:0] ef;
    logic       sd;
    logic       vld;
    int         data;
    logic       chkd;
  } row_t;

  row_t tbl[$];

  task automatic add(input logic [2:0] vec, input logic req, input logic [1:0] sel,
                     input logic [2:0] ef, input logic sd, input logic vld,
                     input int data, input logic chkd);
    row_t r;
    r.vec = vec; r.req = req; r.sel = sel; r.ef = ef;
    r.sd = sd; r.vld = vld; r.data = data; r.chkd = chkd;
    tbl.push_back(r);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [2:0] v);
    out_vec = v;
    step();
  endtask

  int ef1_cnt;
  int sat_exp;

  initial begin
    rst = 1'b1; out_vec = 3'b111; clr = 1'b0; rd_req = 1'b0; rd_sel = 2'd0;
    repeat (3) step();
    chk("reset valid", int'(rd_valid), 0);
    chk("reset data", int'(rd_data), 0);
    chk("reset flags", int'(edge_flags), 0);
    chk("reset seq", int'(seq_det), 0);
    rst = 1'b0;

    // vec, req, sel, flags, seq, valid, data, check-data
    for (int i = 0; i < 10; i++) add(3'b111, 0, 0, 3'b000, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) add(3'b111, 1, 2'(i), 3'b000, 0, 1, 0, 1);
    add(3'b000, 0, 0, 3'b000, 0, 0, 0, 1);
    add(3'b001, 0, 0, 3'b000, 0, 0, 0, 0);
    add(3'b000, 0, 0, 3'b001, 0, 0, 0, 0);
    add(3'b001, 0, 0, 3'b000, 0, 0, 0, 0);
    add(3'b001, 0, 0, 3'b001, 0, 0, 0, 0);
    add(3'b001, 1, 0, 3'b000, 0, 1, 2, 1);
    add(3'b111, 0, 0, 3'b000, 0, 0, 2, 1);
    add(3'b111, 0, 0, 3'b110, 0, 0, 0, 0);
    add(3'b111, 0, 0, 3'b000, 0, 0, 0, 0);
    add(3'b010, 0, 0, 3'b000, 0, 0, 0, 0);
    add(3'b101, 0, 0, 3'b000, 0, 0, 0, 0);
    add(3'b101, 0, 0, 3'b101, 1, 0, 0, 0);
    add(3'b101, 1, 3, 3'b000, 0, 1, 1, 1);
    add(3'b111, 0, 0, 3'b000, 0, 0, 0, 0);
    add(3'b010, 0, 0, 3'b010, 0, 0, 0, 0);
    add(3'b011, 0, 0, 3'b000, 0, 0, 0, 0);
    add(3'b101, 0, 0, 3'b001, 0, 0, 0, 0);
    add(3'b101, 1, 3, 3'b100, 0, 1, 1, 1);
    add(3'b101, 1, 2, 3'b000, 0, 1, 3, 1);
    add(3'b101, 1, 1, 3'b000, 0, 1, 2, 1);
    add(3'b101, 1, 0, 3'b000, 0, 1, 4, 1);
    add(3'b101, 0, 0, 3'b000, 0, 0, 4, 1);

    foreach (tbl[i]) begin
      out_vec = tbl[i].vec;
      rd_req  = tbl[i].req;
      rd_sel  = tbl[i].sel;
      step();
      chk($sformatf("row%0d flags", i), int'(edge_flags), int'(tbl[i].ef));
      chk($sformatf("row%0d seq", i), int'(seq_det), int'(tbl[i].sd));
      chk($sformatf("row%0d valid", i), int'(rd_valid), int'(tbl[i].vld));
      if (tbl[i].chkd) chk($sformatf("row%0d data", i), int'(rd_data), tbl[i].data);
    end
    rd_req = 1'b0;

    // Bring channel 2 counter to 5, then an edge lands with CLR and a read
    apply(3'b001);
    apply(3'b101);
    apply(3'b001);
    chk("ch2 edge a", int'(edge_flags), 3'b100);
    apply(3'b101);
    apply(3'b101);
    chk("ch2 edge b", int'(edge_flags), 3'b100);
    apply(3'b001);
    apply(3'b101);
    clr = 1'b1; rd_req = 1'b1; rd_sel = 2'd2;
    step();
    chk("clr read valid", int'(rd_valid), 1);
    chk("clr read data", int'(rd_data), 5);
    chk("clr flags", int'(edge_flags), 0);
    clr = 1'b0;
    step();
    chk("post clr ch2", int'(rd_data), 0);
    rd_sel = 2'd0;
    step();
    chk("post clr ch0", int'(rd_data), 0);
    rd_sel = 2'd3;
    step();
    chk("post clr seq", int'(rd_data), 0);
    rd_req = 1'b0;

    // 20 rising edges on channel 1 against a 4-bit counter
    ef1_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      apply(3'b111);
      if (edge_flags[1]) ef1_cnt++;
      apply(3'b101);
      if (edge_flags[1]) ef1_cnt++;
    end
    chk("ch1 pulse count", ef1_cnt, 20);
    chk("no seq in toggle", int'(seq_det), 0);
`ifdef DIG_MON_WRAP_EN
    sat_exp = 16 + 4;
`else
    sat_exp = 15;
`endif
    rd_req = 1'b1; rd_sel = 2'd1;
    step();
    chk("ch1 saturate", int'(rd_data), sat_exp);

    // Asynchronous reset in the middle of a read
    step();
    chk("pre rst valid", int'(rd_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("async rst valid", int'(rd_valid), 0);
    chk("async rst data", int'(rd_data), 0);
    chk("async rst flags", int'(edge_flags), 0);
    #1 rst = 1'b0;
    step();
    chk("post rst ch1 valid", int'(rd_valid), 1);
    chk("post rst ch1", int'(rd_data), 0);
    rd_sel = 2'd2;
    step();
    chk("post rst ch2", int'(rd_data), 0);
    chk("post rst flags", int'(edge_flags), 0);
    rd_req = 1'b0;
    step();
    chk("post rst idle valid", int'(rd_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dig_out_monitor.md
Name: dig_out_monitor

Overview:
- Downstream consumer of the three-bit registered gate stage (OUT1..OUT3). It re-registers that output vector and counts per-channel rising edges in per-channel counters.
- It detects a configurable three-code sequence on the vector, counted in a fourth counter.
- Exposes all four counters through a one-cycle read handshake for a host or testbench.

Parameters:
- CNT_W, 8, width of each event counter
- PAT_A, 3'b111, first code of detected sequence ({OUT3,OUT2,OUT1} order)
- PAT_B, 3'b010, second code
- PAT_C, 3'b101, third code

Ports:
- CLK  input  1  rising-edge clock, shared with upstream stage
- RST  input  1  asynchronous, active-high reset
- OUT_VEC  input  3  upstream outputs; bit0=OUT1, bit1=OUT2, bit2=OUT3
- CLR  input  1  synchronous clear of all counters and FSM
- RD_REQ  input  1  read request, sampled each rising edge
- RD_SEL  input  2  0..2 = channel counter 0..2, 3 = sequence counter
- RD_DATA  output  CNT_W  read data, valid when RD_VALID=1
- RD_VALID  output  1  one-cycle read strobe
- EDGE_FLAGS  output  3  one-cycle pulse per channel rising edge
- SEQ_DET  output  1  one-cycle pulse on sequence completion

Behaviour:
- Reset (async, RST=1): the registers S0, S1, V0, V1, all counters, FSM=S_IDLE, RD_DATA, RD_VALID, EDGE_FLAGS and SEQ_DET all clear to 0 immediately. Reset mid-read drops RD_VALID with no further response.
- Pipeline:
  - Each edge: S0<=OUT_VEC, S1<=S0, V0<=1, V1<=V0.
  - Priming: V1=0 suppresses edge detection and FSM advance, so no edge is counted for the first two cycles after reset release. A vector held high through reset produces no edge.
  - edge[i] = S0[i] & ~S1[i] & V1.
- Latency: OUT_VEC change sampled at edge k gives EDGE_FLAGS/counter update/FSM transition at edge k+1.
- Counters:
  - Each increments by 1 on its event.
  - Saturate at 2^CNT_W-1 by default (see Optional Feature).
  - Events on different channels in the same cycle all count.
- CLR: at the next edge, zeroes all counters, EDGE_FLAGS, SEQ_DET, and sets FSM=S_IDLE. CLR has priority over a simultaneous increment. The S0/S1/V pipeline is not cleared.
- Sequence FSM (states S_IDLE, S_A, S_AB):
  - Advances only on a code change, i.e. V1=1 and S0!=S1. Held codes keep the current state.
  - S_IDLE: S0==PAT_A -> S_A; otherwise stay.
  - S_A: S0==PAT_B -> S_AB; S0==PAT_A -> S_A; otherwise -> S_IDLE.
  - S_AB: S0==PAT_C -> pulse SEQ_DET for 1 cycle, increment the sequence counter, next state S_A if PAT_C==PAT_A else S_IDLE. S0==PAT_A -> S_A; otherwise -> S_IDLE.
- Read handshake:
  - RD_REQ=1 at edge k registers the selected counter's pre-update value (the value before any increment at edge k) into RD_DATA, and asserts RD_VALID at edge k for one cycle.
  - Back-to-back requests are allowed, one per cycle.
  - RD_DATA holds its value after RD_VALID falls.
  - CLR and RD_REQ in the same cycle: the read returns the pre-clear value.

Optional Feature:
- Macro DIG_MON_WRAP_EN.
- Defined: counters wrap from 2^CNT_W-1 to 0 and set a per-counter sticky overflow bit. RD_DATA is widened to CNT_W+1 with the overflow bit as its MSB. The sticky bits clear on RST or CLR.
- Undefined: counters saturate, and RD_DATA is CNT_W bits.

Decomposition:
- Package dig_mon_pkg holds the FSM state encodings (S_IDLE=2'd0, S_A=2'd1, S_AB=2'd2), the RD_SEL encodings (SEL_CH0..SEL_CH2, SEL_SEQ) and the default pattern constants.
- One sub-module, dig_evt_counter (parameter CNT_W; ports CLK, RST, CLR, INC, CNT, OVF). It contains the saturate/wrap logic under DIG_MON_WRAP_EN and is instantiated 4 times.

Test Plan:
- Release RST with OUT_VEC=3'b111 held for 10 cycles, then read all four counters -> EDGE_FLAGS never asserts; all counters read 0.
- After priming, OUT_VEC 000->001->000->001 on consecutive cycles, then RD_SEL=0 read -> EDGE_FLAGS[0] pulses twice, each 2 edges after its change; RD_DATA=2.
- With CNT_W=4, toggle OUT_VEC[1] for 20 rising edges -> counter 1 reads 15 (undefined macro), or 4 with overflow bit 1 (DIG_MON_WRAP_EN).
- Sequence 111 (held 3 cycles), 010, 101 -> SEQ_DET pulses once; sequence counter reads 1. Sequence 111, 010, 011, 101 -> no pulse.
- Edge on channel 2 coincident with CLR and RD_REQ (RD_SEL=2), counter previously 5 -> RD_DATA=5, RD_VALID=1; a subsequent read returns 0.
- Assert RST during a RD_REQ cycle -> RD_VALID, RD_DATA and all counters go to 0 without waiting for a clock edge.
